// File: rtl/fasta_stream_normalizer.sv
// Purpose: first stage of the FASTA-to-SAM converter. Drops header/comment lines, joins sequence lines,
//          uppercases bases (non-ACGTN letters become 'N') and writes one 0x0A-terminated record per
//          sequence into the sequence memory from address 0, followed by a single END_BYTE.
// Latency: the write caused by a consumed byte appears on wr_* one cycle after the handshake.
// Backpressure: in_ready depends only on state (high in SEQ/HDR); input stalls for good once overflow is hit.
// Ports: clk/rst (async, active-high); start pulse; in_valid/in_ready/in_data/in_last byte stream;
//        wr_addr/wr_data/wr_we memory write port; busy/done/overflow status; rec_count/base_count counters.
module fasta_stream_normalizer #(
    parameter int         ADDR_WIDTH = 15,
    parameter logic [7:0] END_BYTE   = 8'h00,
    parameter int         CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  wr_we,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  rec_count,
    output logic [ADDR_WIDTH-1:0] base_count
);
    typedef enum logic [2:0] {S_IDLE, S_SEQ, S_HDR, S_FLUSH_NL, S_WR_END, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [7:0]            NL        = 8'h0A;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  wr_we_q, wr_we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  rec_q, rec_d;
    logic                  line_start_q, line_start_d;
    logic                  seq_open_q, seq_open_d;

    logic       fire, at_last, is_lower, is_alpha, is_marker, is_blank, do_wr;
    logic [7:0] upper, mapped, wbyte;

    assign in_ready  = (state_q == S_SEQ) || (state_q == S_HDR);
    assign fire      = in_valid && in_ready;
    assign at_last   = (ptr_q == LAST_ADDR);
    assign is_lower  = (in_data >= 8'h61) && (in_data <= 8'h7A);
    assign is_alpha  = is_lower || ((in_data >= 8'h41) && (in_data <= 8'h5A));
    assign upper     = is_lower ? (in_data - 8'h20) : in_data;
    assign is_marker = (in_data == 8'h3E) || (in_data == 8'h3B);
    assign is_blank  = (in_data == 8'h0D) || (in_data == 8'h20) || (in_data == 8'h09);

    always_comb begin
        case (upper)
            8'h41, 8'h43, 8'h47, 8'h54, 8'h4E: mapped = upper;
            default:                           mapped = 8'h4E;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_we_d      = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        ovf_d        = ovf_q;
        rec_d        = rec_q;
        base_d       = base_q;
        line_start_d = line_start_q;
        seq_open_d   = seq_open_q;
        do_wr        = 1'b0;
        wbyte        = 8'h00;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_SEQ;
                    ptr_d        = '0;
                    ovf_d        = 1'b0;
                    rec_d        = '0;
                    base_d       = '0;
                    line_start_d = 1'b1;
                    seq_open_d   = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                end
            end
            S_SEQ: begin
                if (fire) begin
                    state_d = in_last ? S_FLUSH_NL : S_SEQ;
                    if (is_marker && line_start_q) begin
                        // A header/comment closes the open record; with in_last the flush has nothing left to do.
                        if (!in_last) begin
                            state_d = S_HDR;
                        end
                        if (seq_open_q) begin
                            do_wr      = 1'b1;
                            wbyte      = NL;
                            rec_d      = rec_q + CNT_WIDTH'(1);
                            seq_open_d = 1'b0;
                        end
                    end else if (in_data == NL) begin
                        line_start_d = 1'b1;
                    end else if (is_blank) begin
                        line_start_d = line_start_q;
                    end else if (is_alpha) begin
                        do_wr        = 1'b1;
                        wbyte        = mapped;
                        seq_open_d   = 1'b1;
                        line_start_d = 1'b0;
                        base_d       = base_q + ADDR_WIDTH'(1);
                    end else begin
                        line_start_d = 1'b0;
                    end
                end
            end
            S_HDR: begin
                if (fire) begin
                    if (in_data == NL) begin
                        line_start_d = 1'b1;
                        state_d      = S_SEQ;
                    end
                    if (in_last) begin
                        state_d = S_FLUSH_NL;
                    end
                end
            end
            S_FLUSH_NL: begin
                state_d = S_WR_END;
                if (seq_open_q) begin
                    do_wr      = 1'b1;
                    wbyte      = NL;
                    rec_d      = rec_q + CNT_WIDTH'(1);
                    seq_open_d = 1'b0;
                end
            end
            S_WR_END: begin
                wr_addr_d = ptr_q;
                wr_data_d = END_BYTE;
                wr_we_d   = 1'b1;
                ptr_d     = ptr_q + ADDR_WIDTH'(1);
                state_d   = S_DONE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // The last address is reserved for END_BYTE: a base or newline aimed at it is dropped together
        // with its bookkeeping, and the run is closed off with the terminator at that address.
        if (do_wr) begin
            if (at_last) begin
                ovf_d        = 1'b1;
                state_d      = S_WR_END;
                rec_d        = rec_q;
                base_d       = base_q;
                seq_open_d   = seq_open_q;
                line_start_d = line_start_q;
            end else begin
                wr_addr_d = ptr_q;
                wr_data_d = wbyte;
                wr_we_d   = 1'b1;
                ptr_d     = ptr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            wr_we_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            rec_q        <= '0;
            base_q       <= '0;
            line_start_q <= 1'b1;
            seq_open_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_we_q      <= wr_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            rec_q        <= rec_d;
            base_q       <= base_d;
            line_start_q <= line_start_d;
            seq_open_q   <= seq_open_d;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_we      = wr_we_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign rec_count  = rec_q;
    assign base_count = base_q;
endmodule

// File: tb/tb_fasta_stream_normalizer.sv
// Bench for fasta_stream_normalizer: one instance with default parameters, one with ADDR_WIDTH=4
// so the overflow path is reachable; tgt_n selects which instance receives stimulus.
module tb_fasta_stream_normalizer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid, in_last, tgt_n;
    logic [7:0] in_data;

    logic        w_rdy, w_we, w_busy, w_done, w_ovf;
    logic [14:0] w_addr, w_base;
    logic [7:0]  w_dat;
    logic [15:0] w_rec;
    logic        n_rdy, n_we, n_busy, n_done, n_ovf;
    logic [3:0]  n_addr, n_base;
    logic [7:0]  n_dat;
    logic [15:0] n_rec;

    fasta_stream_normalizer dut_w (
        .clk(clk), .rst(rst), .start(start & ~tgt_n), .in_valid(in_valid & ~tgt_n), .in_ready(w_rdy),
        .in_data(in_data), .in_last(in_last), .wr_addr(w_addr), .wr_data(w_dat), .wr_we(w_we),
        .busy(w_busy), .done(w_done), .overflow(w_ovf), .rec_count(w_rec), .base_count(w_base));

    fasta_stream_normalizer #(.ADDR_WIDTH(4)) dut_n (
        .clk(clk), .rst(rst), .start(start & tgt_n), .in_valid(in_valid & tgt_n), .in_ready(n_rdy),
        .in_data(in_data), .in_last(in_last), .wr_addr(n_addr), .wr_data(n_dat), .wr_we(n_we),
        .busy(n_busy), .done(n_done), .overflow(n_ovf), .rec_count(n_rec), .base_count(n_base));

    logic        sel_rdy, sel_we, sel_busy, sel_done, sel_ovf;
    logic [14:0] sel_addr, sel_base;
    logic [7:0]  sel_dat;
    logic [15:0] sel_rec;
    assign sel_rdy  = tgt_n ? n_rdy  : w_rdy;
    assign sel_we   = tgt_n ? n_we   : w_we;
    assign sel_busy = tgt_n ? n_busy : w_busy;
    assign sel_done = tgt_n ? n_done : w_done;
    assign sel_ovf  = tgt_n ? n_ovf  : w_ovf;
    assign sel_addr = tgt_n ? {11'b0, n_addr} : w_addr;
    assign sel_base = tgt_n ? {11'b0, n_base} : w_base;
    assign sel_dat  = tgt_n ? n_dat  : w_dat;
    assign sel_rec  = tgt_n ? n_rec  : w_rec;

    int         total = 0;
    int         bad = 0;
    logic [7:0] stim[$];
    logic [7:0] exp_w[$];
    int         exp_rec, exp_base;
    bit         exp_ovf;
    int         wr_idx = 0;
    bit         armed = 1'b0;
    logic [7:0] mem [0:1023];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input int act, input int exp);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: the memory image follows from the rules directly -- keep letters (mapped), close a record
    // with a newline when a '>'/';' starts a line or the file ends, never let a base/newline take the
    // last address, and finish with the terminator right after the last accepted byte.
    task automatic run_model(input int aw);
        int         last;
        bit         in_hdr, ls, open;
        logic [7:0] b, u;
        last = (1 << aw) - 1;
        in_hdr = 0; ls = 1; open = 0;
        exp_w.delete(); exp_rec = 0; exp_base = 0; exp_ovf = 0;
        for (int i = 0; i < stim.size(); i++) begin
            b = stim[i];
            if (in_hdr) begin
                if (b == 8'h0A) begin in_hdr = 0; ls = 1; end
            end else if ((b == ">" || b == ";") && ls) begin
                if (open) begin
                    if (exp_w.size() == last) begin exp_ovf = 1; break; end
                    exp_w.push_back(8'h0A); exp_rec++; open = 0;
                end
                in_hdr = 1;
            end else if (b == 8'h0A) begin
                ls = 1;
            end else if (b == 8'h0D || b == " " || b == 8'h09) begin
                ls = ls;
            end else if ((b >= "a" && b <= "z") || (b >= "A" && b <= "Z")) begin
                u = (b >= "a") ? b - 8'd32 : b;
                if (!(u inside {"A", "C", "G", "T", "N"})) u = "N";
                if (exp_w.size() == last) begin exp_ovf = 1; break; end
                exp_w.push_back(u); exp_base++; open = 1; ls = 0;
            end else begin
                ls = 0;
            end
        end
        if (!exp_ovf && open) begin
            if (exp_w.size() == last) exp_ovf = 1;
            else begin exp_w.push_back(8'h0A); exp_rec++; end
        end
        exp_w.push_back(8'h00);
    endtask

    // Single compare process: every write strobe is checked against the model's next expected byte.
    always @(negedge clk) begin
        if (tgt_n ? w_we : n_we) fail("unselected_write", 1, 0);
        if (sel_we) begin
            if (!armed) begin
                fail("write_while_idle", int'(sel_addr), -1);
            end else begin
                if (sel_addr < 15'd1024) mem[sel_addr[9:0]] = sel_dat;
                if (wr_idx < exp_w.size()) begin
                    check("wr_addr", int'(sel_addr), wr_idx);
                    check("wr_data", int'(sel_dat), int'(exp_w[wr_idx]));
                end else begin
                    fail("extra_write", wr_idx, exp_w.size());
                end
                wr_idx++;
            end
        end
    end

    task automatic load(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    endtask

    task automatic check_img(input string s);
        for (int i = 0; i < s.len(); i++) check("img", int'(mem[i]), int'(s[i]));
        check("img_end", int'(mem[s.len()]), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"},    int'(w_we) + int'(n_we), 0);
        check({tag, "_addr"},  int'(w_addr) + int'(n_addr), 0);
        check({tag, "_data"},  int'(w_dat) + int'(n_dat), 0);
        check({tag, "_busy"},  int'(w_busy) + int'(n_busy), 0);
        check({tag, "_done"},  int'(w_done) + int'(n_done), 0);
        check({tag, "_ovf"},   int'(w_ovf) + int'(n_ovf), 0);
        check({tag, "_rec"},   int'(w_rec) + int'(n_rec), 0);
        check({tag, "_base"},  int'(w_base) + int'(n_base), 0);
        check({tag, "_ready"}, int'(w_rdy) + int'(n_rdy), 0);
    endtask

    // Presents stim[0..n-1]; in_ready is sampled 1 time unit after an edge, which is its value at the next edge.
    task automatic drive_bytes(input int n, input int gap_pct, output bit stalled);
        bit acc;
        int w;
        stalled = 0;
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 0; in_data = 8'($urandom); in_last = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1; in_data = stim[i]; in_last = (i == stim.size() - 1);
            acc = 0; w = 0;
            while (!acc && w < 20) begin
                acc = sel_rdy;
                @(posedge clk); #1;
                w++;
            end
            if (!acc) begin stalled = 1; break; end
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic run_file(input bit narrow, input int gap_pct);
        bit st;
        int k;
        tgt_n = narrow;
        run_model(narrow ? 4 : 15);
        wr_idx = 0; armed = 1;
        start = 1; @(posedge clk); #1 start = 0;
        check("busy_after_start", int'(sel_busy), 1);
        check("done_after_start", int'(sel_done), 0);
        drive_bytes(stim.size(), gap_pct, st);
        if (st) check("stall_means_overflow", int'(sel_ovf), 1);
        k = 0;
        while (!sel_done && k < 100) begin
            check("ready_low_after_last", int'(sel_rdy), 0);
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100) fail("done_timeout", k, 100);
        if (!exp_ovf && !st) check("done_latency", k, 2);
        @(negedge clk); #1;
        check("done", int'(sel_done), 1);
        check("busy_end", int'(sel_busy), 0);
        check("overflow", int'(sel_ovf), int'(exp_ovf));
        check("rec_count", int'(sel_rec), exp_rec);
        check("base_count", int'(sel_base), exp_base);
        check("write_count", wr_idx, exp_w.size());
    endtask

    task automatic gen_random(input int nrec, input int maxlen);
        string hc = "ab>;1 CG";
        string sc = "ACGTNacgtnRYkx\t 09>;\015";
        int k, nl, len;
        stim.delete();
        for (int r = 0; r < nrec; r++) begin
            k = $urandom_range(9);
            if (k < 7) begin
                stim.push_back((k == 6) ? ";" : ">");
                len = $urandom_range(4);
                for (int j = 0; j < len; j++) stim.push_back(hc[$urandom_range(hc.len() - 1)]);
                stim.push_back(8'h0A);
            end
            nl = $urandom_range(3);
            for (int l = 0; l < nl; l++) begin
                len = $urandom_range(maxlen);
                for (int j = 0; j < len; j++) stim.push_back(sc[$urandom_range(sc.len() - 1)]);
                if ($urandom_range(3) == 0) stim.push_back(8'h0D);
                stim.push_back(8'h0A);
            end
        end
        if (stim.size() > 1 && stim[stim.size() - 1] == 8'h0A && $urandom_range(1) == 1) void'(stim.pop_back());
        if (stim.size() == 0) stim.push_back("A");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit st;
        rst = 1; start = 0; in_valid = 0; in_data = 0; in_last = 0; tgt_n = 0;
        repeat (3) @(posedge clk);
        #1 check_reset("por");
        rst = 0;
        @(posedge clk); #1;
        check("idle_ready", int'(w_rdy), 0);

        // Two records across multiple lines.
        clear_mem();
        load(">r1\nACGT\n>r2\nGG\nTT\n");
        run_file(0, 0);
        check_img("ACGT\nGGTT\n");
        check("s1_rec", int'(w_rec), 2);
        check("s1_base", int'(w_base), 8);
        check("s1_ovf", int'(w_ovf), 0);

        // Lowercase, IUPAC codes, CRLF and embedded blanks.
        clear_mem();
        load(">x\015\nacgRn xT\015\n");
        run_file(0, 0);
        check_img("ACGNNNT\n");
        check("s2_base", int'(w_base), 7);
        check("s2_rec", int'(w_rec), 1);

        // Empty record and comment line.
        clear_mem();
        load(">a\n;note\n>b\nAC\n");
        run_file(0, 0);
        check_img("AC\n");
        check("s3_rec", int'(w_rec), 1);

        // No trailing newline, with valid gaps.
        clear_mem();
        load(">r\nGAT");
        run_file(0, 50);
        check_img("GAT\n");

        // Overflow on the 16-entry instance.
        clear_mem();
        load(">r\n");
        repeat (20) stim.push_back("A");
        run_file(1, 0);
        for (int i = 0; i < 15; i++) check("ovf_img", int'(mem[i]), 8'h41);
        check("ovf_img_end", int'(mem[15]), 0);
        check("ovf_flag", int'(n_ovf), 1);
        check("ovf_base", int'(n_base), 15);
        check("ovf_rec", int'(n_rec), 0);
        check("ovf_ready", int'(n_rdy), 0);

        // Randomised files on both instances.
        for (int it = 0; it < 30; it++) begin
            if (it % 3 == 0) begin
                gen_random(2, 8);
                run_file(1, $urandom_range(40));
            end else begin
                gen_random(4, 12);
                run_file(0, $urandom_range(40));
            end
        end

        // Reset after three bases, then rerun.
        clear_mem();
        load(">r1\nACGT\n>r2\nGG\nTT\n");
        tgt_n = 0;
        run_model(15);
        wr_idx = 0; armed = 1;
        start = 1; @(posedge clk); #1 start = 0;
        drive_bytes(7, 0, st);
        @(negedge clk); #1;
        armed = 0;
        rst = 1;
        #1 check_reset("midrst");
        check("bases_before_rst", wr_idx, 3);
        in_valid = 1; in_data = "A";
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_ready", int'(w_rdy), 0);
        end
        rst = 0;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_rst_ready", int'(w_rdy), 0);
            check("post_rst_busy", int'(w_busy), 0);
        end
        in_valid = 0;
        clear_mem();
        run_file(0, 0);
        check_img("ACGT\nGGTT\n");
        check("rerun_rec", int'(w_rec), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
